boot_uart_rx: RTL
=================

BOOT_UART_RX -- requirements
Module: boot_uart_rx

Interface
REQ-001 SHALL have port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_i  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have port: en_i  input  1  receiver enable; level-sensitive.
REQ-004 SHALL have port: clks_per_bit_i  input  16  clk_i cycles per UART bit; values below 2 are treated as 2.
REQ-005 SHALL have port: rx_i  input  1  asynchronous serial line; idle high, 8N1, LSB first.
REQ-006 SHALL have port: rx_dv_o  output  1  one-cycle pulse; rx_byte_o holds a new valid byte.
REQ-007 SHALL have port: rx_byte_o  output  8  last received byte; held until the next valid byte.
REQ-008 SHALL have port: frame_err_o  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port: busy_o  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL pass rx_i through a 2-flop synchronizer reset to 1; all line decisions use the synchronized value rx_s.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-012 SHALL latch cpb = max(clks_per_bit_i, 2) on the IDLE->START transition; changes to clks_per_bit_i mid-frame have no effect on the current frame.
REQ-013 SHALL leave IDLE for START, with bit counter cnt cleared to 0, when en_i=1 and rx_s=0.
REQ-014 SHALL, in START, increment cnt each cycle and sample rx_s at cnt == (cpb>>1)-1; sample 0 -> DATA with cnt=0 and bit_idx=0; sample 1 -> IDLE (glitch rejected, no output pulse).
REQ-015 SHALL, in DATA, sample rx_s at cnt == cpb-1, shift it into a shift register at position bit_idx (LSB first), and clear cnt; after bit_idx 7 -> STOP.
REQ-016 SHALL, in STOP, sample rx_s at cnt == cpb-1; sample 1 -> load rx_byte_o from the shift register, pulse rx_dv_o for exactly one cycle (the cycle after the sample), then IDLE.
REQ-017 SHALL, on a stop sample of 0, pulse frame_err_o for one cycle, leave rx_byte_o unchanged, not assert rx_dv_o, and enter BREAK.
REQ-018 SHALL remain in BREAK until rx_s=1, then return to IDLE.
REQ-019 SHALL abort to IDLE on the next edge when en_i=0 in any state, with no rx_dv_o or frame_err_o pulse; rx_byte_o retained.
REQ-020 SHALL never assert rx_dv_o and frame_err_o in the same cycle.
REQ-021 SHALL accept back-to-back frames: a start bit beginning immediately after the stop-bit sample is detected without losing a byte.
REQ-022 SHALL size cnt to 16 bits with no wrap within a bit period; cnt is compared for equality only.
REQ-023 SHALL produce rx_dv_o no later than 2 + (cpb>>1) + 9*cpb + 1 cycles after the rx_i falling edge of the start bit.

Reset
REQ-024 SHALL, while rst_i=1, force state=IDLE, cnt=0, bit_idx=0, shift register=0x00, synchronizer flops=1, rx_byte_o=0x00, rx_dv_o=0, frame_err_o=0, busy_o=0.
REQ-025 SHALL, on rst_i assertion mid-frame, discard the partial byte immediately with no output pulse; reception resumes only on a fresh start bit after release.

Verification
REQ-026 SHALL cover: cpb=4, en_i=1, send 0xA5 8N1 -> single rx_dv_o pulse, rx_byte_o=0xA5, frame_err_o never high.
REQ-027 SHALL cover: cpb=4, bytes 0x0F,0xFF,0x00,0x13 sent back-to-back with no idle gap -> four rx_dv_o pulses in order with matching rx_byte_o.
REQ-028 SHALL cover: cpb=8, rx_i low for 2 cycles then high -> returns to IDLE, no rx_dv_o, no frame_err_o, busy_o deasserts.
REQ-029 SHALL cover: cpb=4, send 0x3C with stop bit held low for 20 cycles -> one frame_err_o pulse, no rx_dv_o, rx_byte_o keeps prior value, state stays BREAK until the line goes high, then the next byte 0x55 is received correctly.
REQ-030 SHALL cover: rst_i pulsed during DATA bit 4 of 0xC3 (and separately en_i dropped at the same point) -> no pulse, all outputs at reset values (en_i case: rx_byte_o retained), next 0x81 received correctly.
REQ-031 SHALL cover: clks_per_bit_i=0 and =1 -> behaves as cpb=2, 0x5A received correctly; clks_per_bit_i changed from 4 to 16 mid-frame -> current byte received at cpb=4.

Source files
------------

// File: rtl/boot_uart_rx_if.sv
// Receive-side output bundle of the boot UART: byte strobe, data, framing error and busy.
interface boot_uart_rx_if;
    logic       rx_dv_o;
    logic [7:0] rx_byte_o;
    logic       frame_err_o;
    logic       busy_o;

    modport master (
        output rx_dv_o,
        output rx_byte_o,
        output frame_err_o,
        output busy_o
    );

    modport slave (
        input rx_dv_o,
        input rx_byte_o,
        input frame_err_o,
        input busy_o
    );
endinterface

// File: rtl/boot_uart_rx.sv
// 8N1 UART receiver for the boot loader: mid-bit sampling, glitch rejection,
// framing-error detection with break handling, bit period latched per frame.
module boot_uart_rx (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [15:0]   clks_per_bit_i,
    input  logic          rx_i,
    boot_uart_rx_if.master rx_if
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cpb_q, cpb_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        dv_q, dv_d;
    logic        ferr_q, ferr_d;
    logic [15:0] half_end;
    logic [15:0] bit_end;

    // Idle-high line, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s      <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            cpb_q     <= 16'd2;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            byte_q    <= 8'h00;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cpb_q     <= cpb_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            ferr_q    <= ferr_d;
        end
    end

    assign half_end = (cpb_q >> 1) - 16'd1;
    assign bit_end  = cpb_q - 16'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cpb_d     = cpb_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        dv_d      = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en_i && !rx_s) begin
                    state_d = START;
                    cnt_d   = 16'd0;
                    cpb_d   = (clks_per_bit_i < 16'd2) ? 16'd2 : clks_per_bit_i;
                end
            end
            START: begin
                if (cnt_q == half_end) begin
                    cnt_d     = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == bit_end) begin
                    shift_d[bit_idx_q] = rx_s;
                    cnt_d              = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == bit_end) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disable wins over everything, including a stop sample on the same edge.
        if (!en_i) begin
            state_d   = IDLE;
            cnt_d     = 16'd0;
            bit_idx_d = 3'd0;
            byte_d    = byte_q;
            dv_d      = 1'b0;
            ferr_d    = 1'b0;
        end
    end

    assign rx_if.rx_dv_o     = dv_q;
    assign rx_if.rx_byte_o   = byte_q;
    assign rx_if.frame_err_o = ferr_q;
    assign rx_if.busy_o      = (state_q != IDLE);

endmodule
